// File: rtl/cfg_reg_bank_pkg.sv
// Shared definitions for the system-control configuration bank.
// - Register map constants for the exported UART / clock-divider entries.
// - Default reset constants for those entries.
// - rv_put: helper for building a packed RESET_VALS vector one entry at a time.
package cfg_reg_bank_pkg;

  localparam int unsigned UART_CFG_ADDR  = 2;
  localparam int unsigned DIV_RATIO_ADDR = 3;

  localparam logic [7:0] UART_CFG_RST  = 8'h81;
  localparam logic [7:0] DIV_RATIO_RST = 8'h20;

  // Upper bound on DEPTH*DATA_WIDTH supported by rv_put; callers slice the result.
  localparam int unsigned RV_MAX_BITS = 1024;

  // Returns vals with entry idx (dw bits wide) replaced by the low dw bits of val.
  function automatic logic [RV_MAX_BITS-1:0] rv_put(
    input logic [RV_MAX_BITS-1:0] vals,
    input int unsigned            idx,
    input int unsigned            dw,
    input logic [63:0]            val
  );
    logic [RV_MAX_BITS-1:0] mask;
    logic [RV_MAX_BITS-1:0] field;
    mask  = ((RV_MAX_BITS'(1) << dw) - RV_MAX_BITS'(1)) << (idx * dw);
    field = (RV_MAX_BITS'(val) << (idx * dw)) & mask;
    return (vals & ~mask) | field;
  endfunction

endpackage

// File: rtl/cfg_reg_entry.sv
// One storage cell of the configuration bank.
// Ports:
//   CLK, RST  clock, asynchronous active-low reset (loads RST_VAL)
//   wr_en     qualified write for this entry (range/collision already resolved)
//   wr_data   write data; clear mask in W1C mode
//   hw_set    per-bit hardware set, only used in W1C mode
//   q         current value
// Modes: plain read/write, read-only (RO=1, writes ignored), or sticky
// write-1-to-clear (W1C=1) where hardware set has priority over the bus clear.
module cfg_reg_entry #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
  parameter bit                    RO         = 1'b0,
  parameter bit                    W1C        = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] hw_set,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q <= RST_VAL;
    end else if (W1C) begin
      q <= (wr_en ? (q & ~wr_data) : q) | hw_set;
    end else if (wr_en && !RO) begin
      q <= wr_data;
    end
  end

endmodule

// File: rtl/cfg_reg_bank.sv
// Parametrised configuration/status register bank on the system-control bus.
// Ports:
//   CLK, RST      clock, asynchronous active-low reset
//   WrEn, RdEn    single-cycle write / read requests (both set = collision)
//   Address       entry index
//   WrData        write data (clear mask for the STATUS entry)
//   Status_In     per-bit hardware set of the STATUS entry, sampled every cycle
//   RdData        registered read data, held between reads
//   RdData_Valid  one-cycle pulse with RdData
//   Access_Err    one-cycle pulse: RO/out-of-range write, out-of-range read, collision
//   Cfg_Bus       entries 0..NUM_EXPORT-1, packed
//   Cfg_Changed   one-cycle pulse per exported entry whose value was changed by a write
module cfg_reg_bank
  import cfg_reg_bank_pkg::*;
#(
  parameter int unsigned                  DATA_WIDTH  = 8,
  parameter int unsigned                  ADDR_WIDTH  = 4,
  parameter int unsigned                  DEPTH       = 16,
  parameter int unsigned                  NUM_EXPORT  = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0]  RESET_VALS  = {{((DEPTH - 4) * DATA_WIDTH){1'b0}},
                                                         DATA_WIDTH'(DIV_RATIO_RST),
                                                         DATA_WIDTH'(UART_CFG_RST),
                                                         {(2 * DATA_WIDTH){1'b0}}},
  parameter logic [DEPTH-1:0]             RO_MASK     = '0,
  parameter int unsigned                  STATUS_ADDR = DEPTH - 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             WrEn,
  input  logic                             RdEn,
  input  logic [ADDR_WIDTH-1:0]            Address,
  input  logic [DATA_WIDTH-1:0]            WrData,
  input  logic [DATA_WIDTH-1:0]            Status_In,
  output logic [DATA_WIDTH-1:0]            RdData,
  output logic                             RdData_Valid,
  output logic                             Access_Err,
  output logic [NUM_EXPORT*DATA_WIDTH-1:0] Cfg_Bus,
  output logic [NUM_EXPORT-1:0]            Cfg_Changed
);

  if (DEPTH > (1 << ADDR_WIDTH) || NUM_EXPORT > DEPTH || STATUS_ADDR >= DEPTH) begin : g_bad_params
    $error("cfg_reg_bank: illegal DEPTH/ADDR_WIDTH/NUM_EXPORT/STATUS_ADDR combination");
  end

  logic                  wr_req;
  logic                  rd_req;
  logic                  collision;
  logic                  in_range;
  logic                  ro_hit;
  logic                  wr_err;
  logic                  rd_err;
  logic [DEPTH-1:0]      sel;
  logic [DEPTH-1:0]      we;
  logic [DATA_WIDTH-1:0] ent_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [NUM_EXPORT-1:0] chg_d;

  assign wr_req    = WrEn & ~RdEn;
  assign rd_req    = RdEn & ~WrEn;
  assign collision = WrEn & RdEn;

  // Range and read-only decode come from the one-hot select rather than
  // indexing with Address, so out-of-range addresses simply select nothing.
  assign in_range = |sel;
  assign ro_hit   = |(sel & RO_MASK);
  assign wr_err   = wr_req & (~in_range | ro_hit);
  assign rd_err   = rd_req & ~in_range;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam bit IS_STATUS = (i == STATUS_ADDR);

    assign sel[i] = (Address == ADDR_WIDTH'(i));
    assign we[i]  = wr_req & sel[i] & ~RO_MASK[i];

    cfg_reg_entry #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST_VAL    (RESET_VALS[i*DATA_WIDTH +: DATA_WIDTH]),
      .RO         (RO_MASK[i]),
      .W1C        (IS_STATUS)
    ) u_entry (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (we[i]),
      .wr_data (WrData),
      .hw_set  (IS_STATUS ? Status_In : '0),
      .q       (ent_q[i])
    );
  end

  for (genvar i = 0; i < NUM_EXPORT; i++) begin : g_export
    logic [DATA_WIDTH-1:0] new_val;

    assign Cfg_Bus[i*DATA_WIDTH +: DATA_WIDTH] = ent_q[i];

    if (i == STATUS_ADDR) begin : g_w1c
      assign new_val = (ent_q[i] & ~WrData) | Status_In;
    end else begin : g_plain
      assign new_val = WrData;
    end

    assign chg_d[i] = we[i] & (new_val != ent_q[i]);
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel[i]) rd_mux = rd_mux | ent_q[i];
    end
  end

  // Out-of-range reads return zero because rd_mux selects nothing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdData       <= '0;
      RdData_Valid <= 1'b0;
      Access_Err   <= 1'b0;
      Cfg_Changed  <= '0;
    end else begin
      RdData_Valid <= rd_req;
      Access_Err   <= collision | wr_err | rd_err;
      Cfg_Changed  <= chg_d;
      if (rd_req) RdData <= rd_mux;
    end
  end

endmodule

// File: tb/tb_cfg_reg_bank.sv
module tb_cfg_reg_bank;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned NEXP  = 4;
  localparam int unsigned STAT  = 11;
  localparam logic [DEPTH*DW-1:0] RV = {8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00,
                                        8'h00, 8'h3C, 8'h20, 8'h81, 8'h00, 8'h11};
  localparam logic [DEPTH-1:0] ROM = 12'h010;

  logic              CLK;
  logic              RST;
  logic              WrEn;
  logic              RdEn;
  logic [AW-1:0]     Address;
  logic [DW-1:0]     WrData;
  logic [DW-1:0]     Status_In;
  logic [DW-1:0]     RdData;
  logic              RdData_Valid;
  logic              Access_Err;
  logic [NEXP*DW-1:0] Cfg_Bus;
  logic [NEXP-1:0]   Cfg_Changed;

  cfg_reg_bank #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .NUM_EXPORT  (NEXP),
    .RESET_VALS  (RV),
    .RO_MASK     (ROM),
    .STATUS_ADDR (STAT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .Status_In    (Status_In),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .Access_Err   (Access_Err),
    .Cfg_Bus      (Cfg_Bus),
    .Cfg_Changed  (Cfg_Changed)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    bit          valid;
    bit          err;
    logic [7:0]  data;
    logic [3:0]  chg;
    logic [31:0] bus;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem [DEPTH];
  logic [7:0]  rd_last;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    logic [DEPTH*DW-1:0] rv_v;
    rv_v = RV;
    for (int i = 0; i < DEPTH; i++) mem[i] = rv_v[i*DW +: DW];
    rd_last = 8'h00;
  endtask

  // Issue one request at the falling edge and queue the response the
  // bank must present after the next rising edge.
  task automatic issue(input bit wr, input bit rd, input logic [3:0] addr,
                       input logic [7:0] wd, input logic [7:0] sin, input string tag);
    exp_t e;
    logic [DEPTH-1:0] ro_bits;
    bit status_done;
    ro_bits = ROM;
    status_done = 1'b0;
    @(negedge CLK);
    e.valid = 1'b0;
    e.err   = 1'b0;
    e.chg   = '0;
    e.tag   = tag;
    if (wr && rd) begin
      e.err = 1'b1;
    end else if (rd) begin
      e.valid = 1'b1;
      if (addr < DEPTH) rd_last = mem[addr];
      else begin
        rd_last = 8'h00;
        e.err = 1'b1;
      end
    end else if (wr) begin
      if (addr >= DEPTH || ro_bits[addr]) begin
        e.err = 1'b1;
      end else if (addr == STAT) begin
        mem[STAT] = (mem[STAT] & ~wd) | sin;
        status_done = 1'b1;
      end else begin
        if (addr < NEXP && mem[addr] != wd) e.chg[addr] = 1'b1;
        mem[addr] = wd;
      end
    end
    if (!status_done) mem[STAT] = mem[STAT] | sin;
    e.data = rd_last;
    e.bus  = {mem[3], mem[2], mem[1], mem[0]};
    WrEn      = wr;
    RdEn      = rd;
    Address   = addr;
    WrData    = wd;
    Status_In = sin;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " valid"}, 32'(RdData_Valid), 32'(e.valid));
        check({e.tag, " err"}, 32'(Access_Err), 32'(e.err));
        check({e.tag, " chg"}, 32'(Cfg_Changed), 32'(e.chg));
        check({e.tag, " bus"}, Cfg_Bus, e.bus);
        if (e.valid) check({e.tag, " data"}, 32'(RdData), 32'(e.data));
      end
    end
  end

  initial begin
    RST = 1'b1; WrEn = 1'b0; RdEn = 1'b0; Address = '0; WrData = '0; Status_In = '0;
    model_reset();
    #2 RST = 1'b0;
    #1;
    check("reset rddata", 32'(RdData), 32'h0);
    check("reset valid", 32'(RdData_Valid), 32'h0);
    check("reset err", 32'(Access_Err), 32'h0);
    check("reset chg", 32'(Cfg_Changed), 32'h0);
    check("reset bus", Cfg_Bus, {mem[3], mem[2], mem[1], mem[0]});
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    issue(0, 1, 4'd2, 8'h00, 8'h00, "rd uart");
    issue(0, 1, 4'd3, 8'h00, 8'h00, "rd div");
    issue(0, 0, 4'd0, 8'h00, 8'h00, "idle");
    issue(1, 0, 4'd1, 8'h5A, 8'h00, "wr 5a");
    issue(0, 1, 4'd1, 8'h00, 8'h00, "rd 5a");
    issue(1, 0, 4'd1, 8'h5A, 8'h00, "rewr 5a");
    issue(1, 0, 4'd4, 8'hFF, 8'h00, "wr ro");
    issue(0, 1, 4'd4, 8'h00, 8'h00, "rd ro");
    issue(1, 0, 4'd15, 8'hAA, 8'h00, "wr oor");
    issue(0, 1, 4'd15, 8'h00, 8'h00, "rd oor");
    issue(0, 0, 4'd0, 8'h00, 8'h05, "set stat");
    issue(0, 1, 4'd11, 8'h00, 8'h00, "rd stat5");
    issue(1, 0, 4'd11, 8'h01, 8'h01, "w1c race");
    issue(0, 1, 4'd11, 8'h00, 8'h00, "rd stat5b");
    issue(1, 0, 4'd11, 8'h04, 8'h00, "w1c 04");
    issue(0, 1, 4'd11, 8'h00, 8'h00, "rd stat1");
    issue(1, 1, 4'd0, 8'hFF, 8'h00, "collide");
    issue(0, 1, 4'd0, 8'h00, 8'h00, "rd addr0");
    issue(1, 0, 4'd3, 8'h44, 8'h00, "wr div");

    // Reset while a read response is on the outputs.
    @(negedge CLK);
    WrEn = 1'b0; RdEn = 1'b1; Address = 4'd2; Status_In = '0;
    @(posedge CLK);
    #3;
    RST = 1'b0;
    RdEn = 1'b0;
    #1;
    model_reset();
    check("midrst valid", 32'(RdData_Valid), 32'h0);
    check("midrst rddata", 32'(RdData), 32'h0);
    check("midrst bus", Cfg_Bus, {mem[3], mem[2], mem[1], mem[0]});
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < DEPTH; i++) issue(0, 1, 4'(i), 8'h00, 8'h00, "reload rd");

    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      logic [7:0] sin;
      op  = $urandom_range(0, 9);
      sin = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      if (op == 0)      issue(1, 1, 4'($urandom_range(0, 15)), 8'($urandom), sin, "rnd coll");
      else if (op < 5)  issue(1, 0, 4'($urandom_range(0, 15)), 8'($urandom), sin, "rnd wr");
      else if (op < 9)  issue(0, 1, 4'($urandom_range(0, 15)), 8'($urandom), sin, "rnd rd");
      else              issue(0, 0, 4'($urandom_range(0, 15)), 8'($urandom), sin, "rnd idle");
    end

    @(negedge CLK);
    WrEn = 1'b0; RdEn = 1'b0; Status_In = '0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    check("drain queue", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
